// File: rtl/pipe_ctl_pkg.sv
// Shared encodings for the pipeline stall/flush sequencer:
// register control codes, forward selects, FSM states and helpers.
package pipe_ctl_pkg;

    localparam logic [1:0] CTL_LOAD  = 2'b00;
    localparam logic [1:0] CTL_HOLD  = 2'b01;
    localparam logic [1:0] CTL_FLUSH = 2'b10;

    localparam logic [1:0] FWD_RF    = 2'b00;
    localparam logic [1:0] FWD_EXMEM = 2'b01;
    localparam logic [1:0] FWD_MEMWB = 2'b10;

    localparam logic [4:0] REG_ZERO = 5'd0;
    localparam int         CNT_W    = 8;

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_MUL     = 2'd1,
        ST_MEMWAIT = 2'd2
    } state_e;

    // r0 is hardwired, so a write to it never creates a dependency
    function automatic logic reg_hit(
        input logic [4:0] dst,
        input logic [4:0] src,
        input logic       wen
    );
        return wen && (dst != REG_ZERO) && (dst == src);
    endfunction

endpackage

// File: rtl/pipe_busy_ctr.sv
// Loadable down-counter with freeze and zero flag.
// Tracks the remaining cycles of a multi-cycle EX operation.
module pipe_busy_ctr
    import pipe_ctl_pkg::*;
#(
    parameter int W = CNT_W
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    input  logic         i_freeze,
    output logic [W-1:0] o_cnt,
    output logic         o_zero
);

    logic [W-1:0] r_cnt;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (!i_freeze && (r_cnt != '0)) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign o_cnt  = r_cnt;
    assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/pipe_hazard_ctl.sv
// Stall/flush sequencer for the 5-stage pipeline.
// Define PIPE_FWD_EN to enable operand forwarding; otherwise RAW stalls.
module pipe_hazard_ctl
    import pipe_ctl_pkg::*;
#(
    parameter int MUL_LAT     = 4,
    parameter int MEM_TIMEOUT = 255
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic [4:0] i_id_rs1,
    input  logic       i_id_use_rs1,
    input  logic [4:0] i_id_rs2,
    input  logic       i_id_use_rs2,
    input  logic [4:0] i_ex_destReg,
    input  logic       i_ex_RegWrite,
    input  logic       i_ex_MemToReg,
    input  logic [4:0] i_mem_destReg,
    input  logic       i_mem_RegWrite,
    input  logic       i_ex_redirect,
    input  logic       i_ex_mul_start,
    input  logic       i_mem_access,
    input  logic       i_dmem_ready,
    output logic       o_pc_hold,
    output logic [1:0] o_ifid_ctl,
    output logic [1:0] o_idex_ctl,
    output logic [1:0] o_exmem_ctl,
    output logic [1:0] o_memwb_ctl,
    output logic [1:0] o_fwd_a,
    output logic [1:0] o_fwd_b,
    output logic       o_mem_err
);

    localparam logic [CNT_W-1:0] LP_MUL_INIT = CNT_W'(MUL_LAT - 1);
    localparam logic [CNT_W-1:0] LP_TMO      = CNT_W'(MEM_TIMEOUT);
    localparam logic [CNT_W-1:0] LP_ONE      = CNT_W'(1);

    state_e           r_state;
    state_e           w_state_nxt;
    logic [CNT_W-1:0] r_wcnt;
    logic [CNT_W-1:0] w_wcnt_nxt;
    logic             r_mem_err;
    logic             w_mem_err_nxt;
    logic [CNT_W-1:0] w_mcnt;
    logic             w_mzero;
    logic             w_mload;
    logic             w_mfreeze;
    logic             w_memstall;
    logic             w_s1_ex;
    logic             w_s2_ex;
    logic             w_s1_mem;
    logic             w_s2_mem;
    logic             w_lu;
    logic             w_raw_stall;
    logic [1:0]       w_fwd_a;
    logic [1:0]       w_fwd_b;

    pipe_busy_ctr #(.W(CNT_W)) u_mcnt (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_load     (w_mload),
        .i_load_val (LP_MUL_INIT),
        .i_freeze   (w_mfreeze),
        .o_cnt      (w_mcnt),
        .o_zero     (w_mzero)
    );

    assign w_memstall = i_mem_access & ~i_dmem_ready;

    assign w_s1_ex  = i_id_use_rs1 & reg_hit(i_ex_destReg, i_id_rs1, i_ex_RegWrite);
    assign w_s2_ex  = i_id_use_rs2 & reg_hit(i_ex_destReg, i_id_rs2, i_ex_RegWrite);
    assign w_s1_mem = i_id_use_rs1 & reg_hit(i_mem_destReg, i_id_rs1, i_mem_RegWrite);
    assign w_s2_mem = i_id_use_rs2 & reg_hit(i_mem_destReg, i_id_rs2, i_mem_RegWrite);
    assign w_lu     = i_ex_MemToReg & (w_s1_ex | w_s2_ex);

`ifdef PIPE_FWD_EN
    assign w_raw_stall = w_lu;
    assign w_fwd_a = (w_s1_ex & ~i_ex_MemToReg) ? FWD_EXMEM :
                     w_s1_mem ? FWD_MEMWB : FWD_RF;
    assign w_fwd_b = (w_s2_ex & ~i_ex_MemToReg) ? FWD_EXMEM :
                     w_s2_mem ? FWD_MEMWB : FWD_RF;
`else
    assign w_raw_stall = w_lu | w_s1_ex | w_s2_ex | w_s1_mem | w_s2_mem;
    assign w_fwd_a = FWD_RF;
    assign w_fwd_b = FWD_RF;
`endif

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state   <= ST_RUN;
            r_wcnt    <= '0;
            r_mem_err <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_wcnt    <= w_wcnt_nxt;
            r_mem_err <= w_mem_err_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_wcnt_nxt    = r_wcnt;
        w_mem_err_nxt = r_mem_err;
        w_mload       = 1'b0;
        w_mfreeze     = 1'b1;
        o_pc_hold     = 1'b0;
        o_ifid_ctl    = CTL_LOAD;
        o_idex_ctl    = CTL_LOAD;
        o_exmem_ctl   = CTL_LOAD;
        o_memwb_ctl   = CTL_LOAD;
        unique case (r_state)
            ST_RUN: begin
                if (w_memstall) begin
                    w_state_nxt = ST_MEMWAIT;
                    w_wcnt_nxt  = LP_ONE;
                    o_pc_hold   = 1'b1;
                    o_ifid_ctl  = CTL_HOLD;
                    o_idex_ctl  = CTL_HOLD;
                    o_exmem_ctl = CTL_HOLD;
                    o_memwb_ctl = CTL_FLUSH;
                end else if (i_ex_mul_start) begin
                    w_state_nxt = ST_MUL;
                    w_mload     = 1'b1;
                    o_pc_hold   = 1'b1;
                    o_ifid_ctl  = CTL_HOLD;
                    o_idex_ctl  = CTL_HOLD;
                    o_exmem_ctl = CTL_FLUSH;
                end else if (i_ex_redirect) begin
                    o_ifid_ctl  = CTL_FLUSH;
                    o_idex_ctl  = CTL_FLUSH;
                end else if (w_raw_stall) begin
                    o_pc_hold   = 1'b1;
                    o_ifid_ctl  = CTL_HOLD;
                    o_idex_ctl  = CTL_FLUSH;
                end
            end
            ST_MUL: begin
                if (w_memstall) begin
                    w_state_nxt = ST_MEMWAIT;
                    w_wcnt_nxt  = LP_ONE;
                    o_pc_hold   = 1'b1;
                    o_ifid_ctl  = CTL_HOLD;
                    o_idex_ctl  = CTL_HOLD;
                    o_exmem_ctl = CTL_HOLD;
                    o_memwb_ctl = CTL_FLUSH;
                end else begin
                    w_mfreeze   = 1'b0;
                    o_pc_hold   = 1'b1;
                    o_ifid_ctl  = CTL_HOLD;
                    o_idex_ctl  = CTL_HOLD;
                    // result lands in EX/MEM on the final busy cycle
                    if (w_mcnt == LP_ONE) begin
                        w_state_nxt = ST_RUN;
                    end else begin
                        o_exmem_ctl = CTL_FLUSH;
                    end
                end
            end
            ST_MEMWAIT: begin
                if (i_dmem_ready) begin
                    w_state_nxt = w_mzero ? ST_RUN : ST_MUL;
                    w_wcnt_nxt  = '0;
                end else begin
                    o_pc_hold   = 1'b1;
                    o_ifid_ctl  = CTL_HOLD;
                    o_idex_ctl  = CTL_HOLD;
                    o_exmem_ctl = CTL_HOLD;
                    o_memwb_ctl = CTL_FLUSH;
                    if (r_wcnt != '1) begin
                        w_wcnt_nxt = r_wcnt + 1'b1;
                    end
                end
            end
            default: begin
                w_state_nxt = ST_RUN;
            end
        endcase
        if ((w_state_nxt == ST_MEMWAIT) && (w_wcnt_nxt == LP_TMO)) begin
            w_mem_err_nxt = 1'b1;
        end
        if (!i_rst_n) begin
            o_pc_hold   = 1'b1;
            o_ifid_ctl  = CTL_FLUSH;
            o_idex_ctl  = CTL_FLUSH;
            o_exmem_ctl = CTL_FLUSH;
            o_memwb_ctl = CTL_FLUSH;
        end
    end

    assign o_fwd_a   = i_rst_n ? w_fwd_a : FWD_RF;
    assign o_fwd_b   = i_rst_n ? w_fwd_b : FWD_RF;
    assign o_mem_err = r_mem_err;

endmodule

// File: tb/tb_pipe_hazard_ctl.sv
// Directed bench for pipe_hazard_ctl: reset, load-use, RAW,
// mul occupancy, mem wait, redirect, preemption and timeout.
module tb_pipe_hazard_ctl;

    localparam logic [8:0] P_ALL  = 9'b0_00_00_00_00;
    localparam logic [8:0] P_RST  = 9'b1_10_10_10_10;
    localparam logic [8:0] P_LU   = 9'b1_01_10_00_00;
    localparam logic [8:0] P_MULF = 9'b1_01_01_10_00;
    localparam logic [8:0] P_MULL = 9'b1_01_01_00_00;
    localparam logic [8:0] P_WAIT = 9'b1_01_01_01_10;
    localparam logic [8:0] P_RDR  = 9'b0_10_10_00_00;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [4:0] id_rs1, id_rs2, ex_dst, mem_dst;
    logic       use1, use2, ex_rw, ex_m2r, mem_rw;
    logic       redir, mul_start, mem_acc, dmem_rdy;

    logic       pc_hold, t_pc_hold;
    logic [1:0] ifid, idex, exmem, memwb;
    logic [1:0] t_ifid, t_idex, t_exmem, t_memwb;
    logic [1:0] fwd_a, fwd_b, t_fwd_a, t_fwd_b;
    logic       mem_err, t_mem_err;
    logic [8:0] obs;

    int checks = 0;
    int failures = 0;

    assign obs = {pc_hold, ifid, idex, exmem, memwb};

    always #5 clk = ~clk;

    pipe_hazard_ctl dut (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_id_rs1(id_rs1), .i_id_use_rs1(use1),
        .i_id_rs2(id_rs2), .i_id_use_rs2(use2),
        .i_ex_destReg(ex_dst), .i_ex_RegWrite(ex_rw),
        .i_ex_MemToReg(ex_m2r),
        .i_mem_destReg(mem_dst), .i_mem_RegWrite(mem_rw),
        .i_ex_redirect(redir), .i_ex_mul_start(mul_start),
        .i_mem_access(mem_acc), .i_dmem_ready(dmem_rdy),
        .o_pc_hold(pc_hold), .o_ifid_ctl(ifid),
        .o_idex_ctl(idex), .o_exmem_ctl(exmem),
        .o_memwb_ctl(memwb), .o_fwd_a(fwd_a),
        .o_fwd_b(fwd_b), .o_mem_err(mem_err)
    );

    pipe_hazard_ctl #(.MUL_LAT(4), .MEM_TIMEOUT(3)) dut_t (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_id_rs1(id_rs1), .i_id_use_rs1(use1),
        .i_id_rs2(id_rs2), .i_id_use_rs2(use2),
        .i_ex_destReg(ex_dst), .i_ex_RegWrite(ex_rw),
        .i_ex_MemToReg(ex_m2r),
        .i_mem_destReg(mem_dst), .i_mem_RegWrite(mem_rw),
        .i_ex_redirect(redir), .i_ex_mul_start(mul_start),
        .i_mem_access(mem_acc), .i_dmem_ready(dmem_rdy),
        .o_pc_hold(t_pc_hold), .o_ifid_ctl(t_ifid),
        .o_idex_ctl(t_idex), .o_exmem_ctl(t_exmem),
        .o_memwb_ctl(t_memwb), .o_fwd_a(t_fwd_a),
        .o_fwd_b(t_fwd_b), .o_mem_err(t_mem_err)
    );

    task automatic idle();
        id_rs1 = 5'd0; id_rs2 = 5'd0; use1 = 1'b0; use2 = 1'b0;
        ex_dst = 5'd0; ex_rw = 1'b0; ex_m2r = 1'b0;
        mem_dst = 5'd0; mem_rw = 1'b0;
        redir = 1'b0; mul_start = 1'b0;
        mem_acc = 1'b0; dmem_rdy = 1'b0;
    endtask

    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (obs !== P_RST) begin
                failures++;
                $display("FAIL reset_ctl cyc=%0d obs=%b exp=%b", i, obs, P_RST);
            end
            checks++;
            if ({fwd_a, fwd_b, mem_err} !== 5'b0) begin
                failures++;
                $display("FAIL reset_fwd obs=%b exp=00000", {fwd_a, fwd_b, mem_err});
            end
        end
        rst_n = 1'b1;
        adv();
        @(negedge clk);
        checks++;
        if (obs !== P_ALL) begin
            failures++;
            $display("FAIL reset_release obs=%b exp=%b", obs, P_ALL);
        end
        adv();
    endtask

    task automatic test_load_use();
        ex_m2r = 1'b1; ex_rw = 1'b1; ex_dst = 5'd5;
        id_rs1 = 5'd5; use1 = 1'b1;
        @(negedge clk);
        checks++;
        if (obs !== P_LU) begin
            failures++;
            $display("FAIL load_use_rs1 obs=%b exp=%b", obs, P_LU);
        end
        adv();
        idle();
        @(negedge clk);
        checks++;
        if (obs !== P_ALL) begin
            failures++;
            $display("FAIL load_use_clear obs=%b exp=%b", obs, P_ALL);
        end
        adv();
        ex_m2r = 1'b1; ex_rw = 1'b1; ex_dst = 5'd7;
        id_rs2 = 5'd7; use2 = 1'b1;
        @(negedge clk);
        checks++;
        if (obs !== P_LU) begin
            failures++;
            $display("FAIL load_use_rs2 obs=%b exp=%b", obs, P_LU);
        end
        adv();
        ex_dst = 5'd0; id_rs2 = 5'd0; mem_dst = 5'd0; mem_rw = 1'b1;
        @(negedge clk);
        checks++;
        if (obs !== P_ALL) begin
            failures++;
            $display("FAIL load_use_r0 obs=%b exp=%b", obs, P_ALL);
        end
        adv();
        ex_dst = 5'd9; id_rs2 = 5'd9; use2 = 1'b0;
        @(negedge clk);
        checks++;
        if (obs !== P_ALL) begin
            failures++;
            $display("FAIL load_use_unused obs=%b exp=%b", obs, P_ALL);
        end
        adv();
        idle();
    endtask

    task automatic test_raw();
        ex_rw = 1'b1; ex_dst = 5'd3; id_rs1 = 5'd3; use1 = 1'b1;
        mem_rw = 1'b1; mem_dst = 5'd9; id_rs2 = 5'd9; use2 = 1'b1;
        @(negedge clk);
`ifdef PIPE_FWD_EN
        checks++;
        if ({obs, fwd_a, fwd_b} !== {P_ALL, 2'b01, 2'b10}) begin
            failures++;
            $display("FAIL fwd_split obs=%b exp=%b", {obs, fwd_a, fwd_b},
                     {P_ALL, 2'b01, 2'b10});
        end
`else
        checks++;
        if ({obs, fwd_a, fwd_b} !== {P_LU, 4'b0000}) begin
            failures++;
            $display("FAIL raw_stall_ex obs=%b exp=%b", {obs, fwd_a, fwd_b},
                     {P_LU, 4'b0000});
        end
`endif
        adv();
        ex_rw = 1'b0; id_rs1 = 5'd0; use1 = 1'b0;
        @(negedge clk);
`ifdef PIPE_FWD_EN
        checks++;
        if ({obs, fwd_b} !== {P_ALL, 2'b10}) begin
            failures++;
            $display("FAIL fwd_memwb obs=%b exp=%b", {obs, fwd_b}, {P_ALL, 2'b10});
        end
`else
        checks++;
        if (obs !== P_LU) begin
            failures++;
            $display("FAIL raw_stall_mem obs=%b exp=%b", obs, P_LU);
        end
`endif
        adv();
        mem_dst = 5'd0; id_rs2 = 5'd0; ex_rw = 1'b1; ex_dst = 5'd0;
        @(negedge clk);
        checks++;
        if ({obs, fwd_a, fwd_b} !== {P_ALL, 4'b0000}) begin
            failures++;
            $display("FAIL raw_r0 obs=%b exp=%b", {obs, fwd_a, fwd_b}, {P_ALL, 4'b0000});
        end
        adv();
        idle();
    endtask

    task automatic test_mul();
        logic [8:0] exp_q [4];
        exp_q[0] = P_MULF; exp_q[1] = P_MULF;
        exp_q[2] = P_MULF; exp_q[3] = P_MULL;
        mul_start = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++;
            if (obs !== exp_q[i]) begin
                failures++;
                $display("FAIL mul_cyc%0d obs=%b exp=%b", i, obs, exp_q[i]);
            end
            adv();
            mul_start = 1'b0;
        end
        @(negedge clk);
        checks++;
        if (obs !== P_ALL) begin
            failures++;
            $display("FAIL mul_done obs=%b exp=%b", obs, P_ALL);
        end
        adv();
    endtask

    task automatic test_memwait();
        mem_acc = 1'b1; dmem_rdy = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if (obs !== P_WAIT) begin
                failures++;
                $display("FAIL memwait_cyc%0d obs=%b exp=%b", i, obs, P_WAIT);
            end
            adv();
        end
        dmem_rdy = 1'b1;
        @(negedge clk);
        checks++;
        if (obs !== P_ALL) begin
            failures++;
            $display("FAIL memwait_ready obs=%b exp=%b", obs, P_ALL);
        end
        adv();
        idle();
        @(negedge clk);
        checks++;
        if ({obs, mem_err} !== {P_ALL, 1'b0}) begin
            failures++;
            $display("FAIL memwait_after obs=%b exp=%b", {obs, mem_err}, {P_ALL, 1'b0});
        end
        adv();
    endtask

    task automatic test_redirect();
        redir = 1'b1;
        ex_m2r = 1'b1; ex_rw = 1'b1; ex_dst = 5'd4;
        id_rs1 = 5'd4; use1 = 1'b1;
        @(negedge clk);
        checks++;
        if (obs !== P_RDR) begin
            failures++;
            $display("FAIL redirect_vs_lu obs=%b exp=%b", obs, P_RDR);
        end
        adv();
        idle();
        redir = 1'b1;
        @(negedge clk);
        checks++;
        if (obs !== P_RDR) begin
            failures++;
            $display("FAIL redirect_only obs=%b exp=%b", obs, P_RDR);
        end
        adv();
        idle();
    endtask

    task automatic test_mul_preempt();
        logic [8:0] exp_q [7];
        logic       acc_q [7];
        logic       rdy_q [7];
        exp_q = '{P_MULF, P_MULF, P_WAIT, P_WAIT, P_ALL, P_MULF, P_MULL};
        acc_q = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        rdy_q = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        for (int i = 0; i < 7; i++) begin
            mul_start = (i == 0);
            mem_acc = acc_q[i];
            dmem_rdy = rdy_q[i];
            @(negedge clk);
            checks++;
            if (obs !== exp_q[i]) begin
                failures++;
                $display("FAIL preempt_cyc%0d obs=%b exp=%b", i, obs, exp_q[i]);
            end
            adv();
        end
        idle();
        @(negedge clk);
        checks++;
        if (obs !== P_ALL) begin
            failures++;
            $display("FAIL preempt_done obs=%b exp=%b", obs, P_ALL);
        end
        adv();
    endtask

    task automatic test_reset_mid();
        mul_start = 1'b1;
        @(negedge clk);
        adv();
        mul_start = 1'b0;
        rst_n = 1'b0;
        #1;
        checks++;
        if (obs !== P_RST) begin
            failures++;
            $display("FAIL reset_mid_async obs=%b exp=%b", obs, P_RST);
        end
        @(negedge clk);
        rst_n = 1'b1;
        adv();
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            checks++;
            if (obs !== P_ALL) begin
                failures++;
                $display("FAIL reset_mid_run%0d obs=%b exp=%b", i, obs, P_ALL);
            end
            adv();
        end
    endtask

    task automatic test_timeout();
        logic exp_err [6];
        exp_err = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        rst_n = 1'b0;
        @(negedge clk);
        checks++;
        if (t_mem_err !== 1'b0) begin
            failures++;
            $display("FAIL timeout_reset obs=%b exp=0", t_mem_err);
        end
        rst_n = 1'b1;
        adv();
        mem_acc = 1'b1;
        for (int i = 0; i < 6; i++) begin
            dmem_rdy = (i == 4);
            @(negedge clk);
            checks++;
            if ({t_mem_err, mem_err} !== {exp_err[i], 1'b0}) begin
                failures++;
                $display("FAIL timeout_cyc%0d obs=%b exp=%b", i,
                         {t_mem_err, mem_err}, {exp_err[i], 1'b0});
            end
            if (i == 4) begin
                checks++;
                if ({t_pc_hold, t_ifid, t_idex, t_exmem, t_memwb} !== P_ALL) begin
                    failures++;
                    $display("FAIL timeout_ready obs=%b exp=%b",
                             {t_pc_hold, t_ifid, t_idex, t_exmem, t_memwb}, P_ALL);
                end
                mem_acc = 1'b0;
            end
            adv();
        end
        idle();
    endtask

    initial begin
        rst_n = 1'b0;
        idle();
        test_reset();
        test_load_use();
        test_raw();
        test_mul();
        test_memwait();
        test_redirect();
        test_mul_preempt();
        test_reset_mid();
        test_timeout();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
